// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Scan-code constants, FSM state and FIFO entry types for the
//            PS/2 keycode filter.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } ps2_entry_t;

    // Device-to-host response bytes carry no key information.
    function automatic logic is_response(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_BAT_OK) || (b == SC_ECHO) ||
               (b == SC_ACK)  || (b == SC_RESEND) || (b == SC_ERR1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_code_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_code_fifo
// Brief    : Synchronous FIFO with wrap-bit pointers; push while full is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_code_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [c_ADDR_W:0]  r_wr_ptr;
    logic [c_ADDR_W:0]  r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                       (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_ADDR_W+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keycode_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keycode_filter
// Brief    : Strips PS/2 prefixes, breaks, typematic repeats and responses;
//            buffers genuine make codes and releases them under sink_ready.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keycode_filter
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_received_data,
    input  logic       ps2_received_data_strb,
    input  logic       sink_ready,
    output logic [7:0] key_code,
    output logic       key_code_extended,
    output logic       key_code_strb,
    output logic       overflow
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
    // Compared before the increment, so the FSM lands in IDLE on the edge
    // where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 2);

    ps2_state_t         r_state;
    ps2_entry_t         r_held;
    logic               r_held_valid;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_key_code;
    logic               r_key_code_extended;
    logic               r_key_code_strb;
    logic               r_overflow;

    logic               w_is_prefix;
    logic               w_is_resp;
    logic               w_make;
    logic               w_release;
    logic               w_ext;
    logic               w_repeat;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    ps2_entry_t         w_entry;
    ps2_entry_t         w_fifo_out;

    assign w_is_prefix = (ps2_received_data == SC_EXT) || (ps2_received_data == SC_BRK);
    assign w_is_resp   = is_response(ps2_received_data);

    always_comb begin
        w_make    = 1'b0;
        w_release = 1'b0;
        w_ext     = 1'b0;
        if (ps2_received_data_strb && !w_is_resp && !w_is_prefix) begin
            case (r_state)
                ST_IDLE:    w_make = 1'b1;
                ST_EXT:     begin w_make = 1'b1;    w_ext = 1'b1; end
                ST_BRK:     w_release = 1'b1;
                ST_EXT_BRK: begin w_release = 1'b1; w_ext = 1'b1; end
                default:    w_make = 1'b0;
            endcase
        end
        w_entry.ext  = w_ext;
        w_entry.code = ps2_received_data;
        w_repeat     = r_held_valid && (w_entry == r_held);
        w_push       = w_make && !w_repeat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_held       <= '0;
            r_held_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (ps2_received_data_strb) begin
                r_cnt <= '0;
                if (!w_is_resp) begin
                    case (r_state)
                        ST_IDLE: begin
                            if (ps2_received_data == SC_EXT)      r_state <= ST_EXT;
                            else if (ps2_received_data == SC_BRK) r_state <= ST_BRK;
                        end
                        ST_EXT: begin
                            if (ps2_received_data == SC_BRK)      r_state <= ST_EXT_BRK;
                            else if (ps2_received_data != SC_EXT) r_state <= ST_IDLE;
                        end
                        ST_BRK: begin
                            if (ps2_received_data == SC_EXT)      r_state <= ST_EXT_BRK;
                            else if (ps2_received_data != SC_BRK) r_state <= ST_IDLE;
                        end
                        ST_EXT_BRK: begin
                            if (!w_is_prefix) r_state <= ST_IDLE;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end else if (r_state != ST_IDLE) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end

            if (w_push) begin
                r_held       <= w_entry;
                r_held_valid <= 1'b1;
            end else if (w_release && (w_entry == r_held)) begin
                r_held_valid <= 1'b0;
            end
        end
    end

    assign w_pop = sink_ready && !w_empty;

    ps2_code_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code          <= 8'h00;
            r_key_code_extended <= 1'b0;
            r_key_code_strb     <= 1'b0;
            r_overflow          <= 1'b0;
        end else begin
            r_key_code_strb <= w_pop;
            if (w_pop) begin
                r_key_code          <= w_fifo_out.code;
                r_key_code_extended <= w_fifo_out.ext;
            end
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign key_code          = r_key_code;
    assign key_code_extended = r_key_code_extended;
    assign key_code_strb     = r_key_code_strb;
    assign overflow          = r_overflow;

endmodule
`default_nettype wire
